// File: rtl/mem_resp_pkg.sv
// Shared types and defaults for the memory responder.
//   state_t  : responder FSM states (IDLE, WAIT, ACCESS)
//   op_t     : latched operation kind (OP_READ, OP_WRITE, OP_BAD)
//   ADDR_W_DEF / DATA_W_DEF : default word-address and data widths
//   decode_op: maps the two request levels onto an op_t
package mem_resp_pkg;

    localparam int ADDR_W_DEF = 9;
    localparam int DATA_W_DEF = 32;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        OP_READ  = 2'd0,
        OP_WRITE = 2'd1,
        OP_BAD   = 2'd2
    } op_t;

    // Both requests asserted together is a protocol error, not a priority case.
    function automatic op_t decode_op(input logic rd, input logic wr);
        if (rd && wr) begin
            return OP_BAD;
        end else if (wr) begin
            return OP_WRITE;
        end else begin
            return OP_READ;
        end
    endfunction

endpackage

// File: rtl/mem_array.sv
// Synchronous word array with a single write port and a registered read port.
//   clock   : rising-edge clock
//   reset_n : asynchronous active-low reset (clears the read register only)
//   we      : write enable, array[addr] <= wdata on the edge
//   re      : read enable, rdata <= array[addr] on the edge
//   addr    : word address
//   wdata   : write data
//   rdata   : registered read data, holds until the next enabled read
module mem_array
    import mem_resp_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              we,
    input  logic              re,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata
);

    localparam int DEPTH = 1 << ADDR_W;

    logic [DATA_W-1:0] mem [0:DEPTH-1];

    // Storage has no reset so it maps onto plain RAM.
    always_ff @(posedge clock) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Memory-side responder for the MAR/MDR interface. Accepts one read or write
// request at a time, inserts WAIT_STATES wait cycles, performs the access and
// signals completion with a one-cycle ready pulse.
//   clock     : rising-edge clock
//   reset_n   : asynchronous active-low reset
//   req_read  : read request level, sampled only in IDLE
//   req_write : write request level, sampled only in IDLE
//   addr      : word address (MAR)
//   wdata     : write data (bus/MDR)
//   rdata     : registered read data to MDR, changes only on a completed read
//   ready     : one-cycle completion pulse
//   busy      : high while a request is in flight
//   err       : completion status, valid only while ready=1
// Optional feature: define MEM_PROTECT_EN to reject writes to addresses below
// PROT_TOP (completed with err=1, nothing committed).
module mem_responder
    import mem_resp_pkg::*;
#(
    parameter int          ADDR_W      = ADDR_W_DEF,
    parameter int          DATA_W      = DATA_W_DEF,
    parameter int          WAIT_STATES = 2,
    parameter int unsigned PROT_TOP    = 64
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_read,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] addr,
    input  logic [DATA_W-1:0] wdata,
    output logic [DATA_W-1:0] rdata,
    output logic              ready,
    output logic              busy,
    output logic              err
);

`ifdef MEM_PROTECT_EN
    localparam bit PROTECT = 1'b1;
`else
    localparam bit PROTECT = 1'b0;
`endif

    state_t            state;
    op_t               op;
    logic [3:0]        cnt;
    logic [ADDR_W-1:0] lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic              accept;
    logic              prot_fail;
    logic              mem_we;
    logic              mem_re;

    assign accept = (state == IDLE) && (req_read || req_write);

    // With protection compiled out PROTECT is 0 and the compare folds away.
    assign prot_fail = PROTECT && (op == OP_WRITE) && (32'(lat_addr) < PROT_TOP);

    // The access itself happens on the edge that leaves ACCESS.
    assign mem_we = (state == ACCESS) && (op == OP_WRITE) && !prot_fail;
    assign mem_re = (state == ACCESS) && (op == OP_READ);

    // Request operands are data only; they need no reset.
    always_ff @(posedge clock) begin
        if (accept) begin
            lat_addr  <= addr;
            lat_wdata <= wdata;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
            op    <= OP_READ;
            cnt   <= 4'd0;
            ready <= 1'b0;
            busy  <= 1'b0;
            err   <= 1'b0;
        end else begin
            ready <= 1'b0;
            err   <= 1'b0;
            case (state)
                IDLE: begin
                    if (req_read || req_write) begin
                        op    <= decode_op(req_read, req_write);
                        cnt   <= 4'(WAIT_STATES);
                        busy  <= 1'b1;
                        state <= (WAIT_STATES > 0) ? WAIT : ACCESS;
                    end
                end
                WAIT: begin
                    cnt <= cnt - 4'd1;
                    if (cnt == 4'd1) begin
                        state <= ACCESS;
                    end
                end
                ACCESS: begin
                    ready <= 1'b1;
                    err   <= (op == OP_BAD) || prot_fail;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    mem_array #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_array (
        .clock   (clock),
        .reset_n (reset_n),
        .we      (mem_we),
        .re      (mem_re),
        .addr    (lat_addr),
        .wdata   (lat_wdata),
        .rdata   (rdata)
    );

endmodule
